// File: rtl/midi_note_parser_if.sv
// Byte-stream input and held-note level outputs of the MIDI note parser.
interface midi_note_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] midi_data;
    logic       midi_valid;
    logic [6:0] velocity;
    logic [3:0] stack_count;

    // Byte source side: drives the received byte, observes the note outputs.
    modport master (
        output rx_data,
        output rx_valid,
        input  midi_data,
        input  midi_valid,
        input  velocity,
        input  stack_count
    );

    // Parser side: consumes bytes, drives the note outputs.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output midi_data,
        output midi_valid,
        output velocity,
        output stack_count
    );
endinterface

// File: rtl/midi_note_parser.sv
// MIDI Note On/Off decoder with running status, channel filter and a
// last-note-priority held-note stack for monophonic legato playback.
module midi_note_parser #(
    parameter int CHANNEL     = 0,
    parameter int OMNI        = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    midi_note_parser_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    // Parser state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_status;
    logic [7:0]  w_status_nxt;
    logic [6:0]  r_d1;
    logic [6:0]  w_d1_nxt;

    // Completed-message decode
    logic        w_msg_done;
    logic [6:0]  w_msg_d1;
    logic [6:0]  w_msg_d2;
    logic        w_ch_match;
    logic        w_push;
    logic        w_release;
    logic        w_clear;

    // Held-note stack: index 0 is the oldest entry, r_cnt-1 is the top.
    logic [6:0]  r_note [STACK_DEPTH];
    logic [6:0]  r_vel  [STACK_DEPTH];
    logic [3:0]  r_cnt;
    logic [6:0]  w_note_nxt [STACK_DEPTH];
    logic [6:0]  w_vel_nxt  [STACK_DEPTH];
    logic [3:0]  w_cnt_nxt;
    logic        w_hit;
    logic [3:0]  w_hit_idx;
    logic        w_shift_en;
    logic [3:0]  w_shift_from;
    logic        w_place_en;
    logic [3:0]  w_place_pos;
    logic [6:0]  w_top_note;
    logic [6:0]  w_top_vel;

    // Registered outputs
    logic [7:0]  r_midi_data;
    logic        r_midi_valid;
    logic [6:0]  r_velocity;

    wire  [7:0]  w_byte = bus.rx_data;
    wire         w_data_byte = bus.rx_valid && !w_byte[7];
    wire  [3:0]  w_st_hi = r_status[7:4];
    wire         w_one_data = (w_st_hi == 4'hC) || (w_st_hi == 4'hD);

    // FSM state register: parser state and running status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_status <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
        end
    end

    // First data byte latch; only meaningful while waiting for d2
    always_ff @(posedge clk) begin
        r_d1 <= w_d1_nxt;
    end

    // FSM next-state logic: classify the byte and advance the parser
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_d1_nxt     = r_d1;
        if (bus.rx_valid) begin
            if (w_byte >= 8'hF8) begin
                // realtime: leave everything untouched
                w_state_nxt = r_state;
            end else if (w_byte >= 8'hF0) begin
                w_state_nxt  = IDLE;
                w_status_nxt = 8'h00;
            end else if (w_byte[7]) begin
                w_state_nxt  = WAIT_D1;
                w_status_nxt = w_byte;
            end else begin
                case (r_state)
                    WAIT_D1: begin
                        w_d1_nxt    = w_byte[6:0];
                        w_state_nxt = w_one_data ? WAIT_D1 : WAIT_D2;
                    end
                    WAIT_D2: w_state_nxt = WAIT_D1;
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    // FSM output logic: flag a completed message and its data bytes
    always_comb begin
        w_msg_done = 1'b0;
        w_msg_d1   = w_byte[6:0];
        w_msg_d2   = 7'd0;
        if (w_data_byte) begin
            if (r_state == WAIT_D2) begin
                w_msg_done = 1'b1;
                w_msg_d1   = r_d1;
                w_msg_d2   = w_byte[6:0];
            end else if (r_state == WAIT_D1 && w_one_data) begin
                w_msg_done = 1'b1;
            end
        end
    end

    // Map a completed message on our channel to a stack action
    always_comb begin
        w_ch_match = (OMNI != 0) || (r_status[3:0] == 4'(CHANNEL));
        w_push     = w_msg_done && w_ch_match && (w_st_hi == 4'h9) && (w_msg_d2 != 7'd0);
        w_release  = w_msg_done && w_ch_match &&
                     ((w_st_hi == 4'h8) || ((w_st_hi == 4'h9) && (w_msg_d2 == 7'd0)));
        w_clear    = w_msg_done && w_ch_match && (w_st_hi == 4'hB) && (w_msg_d1 == 7'd123);
    end

    // Stack update: search, shift out the removed slot, place the new top
    always_comb begin
        w_note_nxt   = r_note;
        w_vel_nxt    = r_vel;
        w_cnt_nxt    = r_cnt;
        w_hit        = 1'b0;
        w_hit_idx    = 4'd0;
        w_shift_en   = 1'b0;
        w_shift_from = 4'd0;
        w_place_en   = 1'b0;
        w_place_pos  = 4'd0;
        w_top_note   = 7'd0;
        w_top_vel    = 7'd0;

        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!w_hit && (4'(i) < r_cnt) && (r_note[i] == w_msg_d1)) begin
                w_hit     = 1'b1;
                w_hit_idx = 4'(i);
            end
        end

        if (w_clear) begin
            w_cnt_nxt = 4'd0;
        end else if (w_push) begin
            w_place_en = 1'b1;
            if (w_hit) begin
                w_shift_en   = 1'b1;
                w_shift_from = w_hit_idx;
                w_place_pos  = r_cnt - 4'd1;
            end else if (r_cnt == 4'(STACK_DEPTH)) begin
                w_shift_en   = 1'b1;
                w_shift_from = 4'd0;
                w_place_pos  = r_cnt - 4'd1;
            end else begin
                w_place_pos  = r_cnt;
                w_cnt_nxt    = r_cnt + 4'd1;
            end
        end else if (w_release && w_hit) begin
            w_shift_en   = 1'b1;
            w_shift_from = w_hit_idx;
            w_cnt_nxt    = r_cnt - 4'd1;
        end

        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            if (w_shift_en && (4'(i) >= w_shift_from)) begin
                w_note_nxt[i] = r_note[i+1];
                w_vel_nxt[i]  = r_vel[i+1];
            end
        end

        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_place_en && (4'(i) == w_place_pos)) begin
                w_note_nxt[i] = w_msg_d1;
                w_vel_nxt[i]  = w_msg_d2;
            end
        end

        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (4'(i) + 4'd1 == w_cnt_nxt) begin
                w_top_note = w_note_nxt[i];
                w_top_vel  = w_vel_nxt[i];
            end
        end
    end

    // Stack contents; validity is carried by r_cnt so entries need no reset
    always_ff @(posedge clk) begin
        r_note <= w_note_nxt;
        r_vel  <= w_vel_nxt;
    end

    // Count and output registers; note/velocity hold when the stack empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= 4'd0;
            r_midi_valid <= 1'b0;
            r_midi_data  <= 8'd0;
            r_velocity   <= 7'd0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_midi_valid <= (w_cnt_nxt != 4'd0);
            if (w_cnt_nxt != 4'd0) begin
                r_midi_data <= {1'b0, w_top_note};
                r_velocity  <= w_top_vel;
            end
        end
    end

    assign bus.midi_data   = r_midi_data;
    assign bus.midi_valid  = r_midi_valid;
    assign bus.velocity    = r_velocity;
    assign bus.stack_count = r_cnt;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: a channel-0 instance and an OMNI
// instance receive the same byte stream.
module tb_midi_note_parser;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    midi_note_parser_if u_if0 ();
    midi_note_parser_if u_if1 ();

    midi_note_parser #(.CHANNEL(0), .OMNI(0), .STACK_DEPTH(4)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0)
    );

    midi_note_parser #(.CHANNEL(0), .OMNI(1), .STACK_DEPTH(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one cycle; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        u_if0.rx_valid = 1'b1;
        u_if0.rx_data  = b;
        u_if1.rx_valid = 1'b1;
        u_if1.rx_data  = b;
        @(negedge clk);
        u_if0.rx_valid = 1'b0;
        u_if1.rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a);
        send(b);
        send(c);
    endtask

    task automatic clear_all();
        send3(8'hB0, 8'h7B, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        u_if0.rx_valid = 1'b0;
        u_if0.rx_data  = 8'h00;
        u_if1.rx_valid = 1'b0;
        u_if1.rx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", u_if0.midi_data, 0);
        chk("rst_valid", u_if0.midi_valid, 0);
        chk("rst_vel", u_if0.velocity, 0);
        chk("rst_cnt", u_if0.stack_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic note on / off
        send3(8'h90, 8'h3C, 8'h64);
        chk("basic_data", u_if0.midi_data, 60);
        chk("basic_valid", u_if0.midi_valid, 1);
        chk("basic_vel", u_if0.velocity, 100);
        chk("basic_cnt", u_if0.stack_count, 1);
        send3(8'h80, 8'h3C, 8'h00);
        chk("off_valid", u_if0.midi_valid, 0);
        chk("off_data_hold", u_if0.midi_data, 60);
        chk("off_vel_hold", u_if0.velocity, 100);
        chk("off_cnt", u_if0.stack_count, 0);

        // Running status and velocity-0 release
        send3(8'h90, 8'h3C, 8'h40);
        send(8'h3E);
        send(8'h40);
        chk("rs_data", u_if0.midi_data, 62);
        chk("rs_cnt", u_if0.stack_count, 2);
        chk("rs_vel", u_if0.velocity, 64);
        send(8'h3E);
        send(8'h00);
        chk("rs_fall_data", u_if0.midi_data, 60);
        chk("rs_fall_valid", u_if0.midi_valid, 1);
        send(8'h3C);
        send(8'h00);
        chk("rs_empty_valid", u_if0.midi_valid, 0);

        // Overflow: 60 gets dropped when 67 arrives
        send3(8'h90, 8'h3C, 8'h64);
        send(8'h3E); send(8'h64);
        send(8'h40); send(8'h64);
        send(8'h41); send(8'h64);
        send(8'h43); send(8'h64);
        chk("ovf_cnt", u_if0.stack_count, 4);
        chk("ovf_top", u_if0.midi_data, 67);
        send3(8'h80, 8'h43, 8'h00);
        chk("ovf_rel67_top", u_if0.midi_data, 65);
        send(8'h41); send(8'h00);
        send(8'h40); send(8'h00);
        send(8'h3E); send(8'h00);
        chk("ovf_valid", u_if0.midi_valid, 0);
        chk("ovf_cnt0", u_if0.stack_count, 0);

        // Re-press moves the note to the top with its new velocity
        send3(8'h90, 8'h3C, 8'h10);
        send(8'h3E); send(8'h20);
        send(8'h40); send(8'h30);
        chk("rp_top_before", u_if0.midi_data, 64);
        send(8'h3E); send(8'h50);
        chk("rp_top", u_if0.midi_data, 62);
        chk("rp_vel", u_if0.velocity, 80);
        chk("rp_cnt", u_if0.stack_count, 3);
        send(8'h3E); send(8'h00);
        chk("rp_next_data", u_if0.midi_data, 64);
        chk("rp_next_vel", u_if0.velocity, 48);
        send(8'h40); send(8'h00);
        chk("rp_last_data", u_if0.midi_data, 60);
        chk("rp_last_vel", u_if0.velocity, 16);
        send(8'h3C); send(8'h00);
        chk("rp_empty", u_if0.stack_count, 0);

        // Channel filter vs OMNI
        send3(8'h91, 8'h3C, 8'h64);
        chk("ch_filt_valid", u_if0.midi_valid, 0);
        chk("ch_filt_cnt", u_if0.stack_count, 0);
        chk("omni_valid", u_if1.midi_valid, 1);
        chk("omni_data", u_if1.midi_data, 60);
        clear_all();
        chk("omni_clr", u_if1.stack_count, 0);

        // Realtime byte between d1 and d2 is transparent
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        chk("rt_valid", u_if0.midi_valid, 1);
        chk("rt_data", u_if0.midi_data, 60);
        clear_all();
        chk("clr1_valid", u_if0.midi_valid, 0);

        // System byte abandons the message; trailing data discarded in IDLE
        send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
        chk("sys_valid", u_if0.midi_valid, 0);
        chk("sys_cnt", u_if0.stack_count, 0);

        // Program change is one data byte; its running data is not a note
        send3(8'hC0, 8'h05, 8'h3C);
        chk("pc_cnt", u_if0.stack_count, 0);

        // All Notes Off with three held
        send3(8'h90, 8'h3C, 8'h64);
        send(8'h3E); send(8'h64);
        send(8'h40); send(8'h64);
        chk("anf_pre_cnt", u_if0.stack_count, 3);
        clear_all();
        chk("anf_valid", u_if0.midi_valid, 0);
        chk("anf_cnt", u_if0.stack_count, 0);

        // Reset mid-message: the trailing data byte must be discarded
        send(8'h90); send(8'h3C);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h64);
        chk("rmid_data", u_if0.midi_data, 0);
        chk("rmid_valid", u_if0.midi_valid, 0);
        chk("rmid_vel", u_if0.velocity, 0);
        chk("rmid_cnt", u_if0.stack_count, 0);

        // Reset while notes held clears outputs without waiting for a clock
        send3(8'h90, 8'h45, 8'h33);
        chk("rhold_pre_valid", u_if0.midi_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rhold_async_valid", u_if0.midi_valid, 0);
        chk("rhold_async_data", u_if0.midi_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
